tabla_scan: RTL and testbench

Sequencer that exhaustively sweeps a 3-input combinational truth-table block and records its response. It sits directly upstream and downstream of the 8:1 / 4:1 / 2:1 table implementations. It drives their 3-bit select/variable input through rows 000→111, waits a programmable settle time, samples the 1-bit function output, and assembles the 8-bit truth table. An optional comparator checks the captured table against an expected pattern.

---
 rtl/tabla_scan.sv | 127 ++++++++++++
 tb/tb_tabla_scan.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tabla_scan.sv
// tabla_scan: drives sel through rows 0..7, samples f_in after SETTLE+1 cycles per row.
// Optional comparator against `expected` is compiled in with `define TABLA_CHECK_EN.
`timescale 1ns/1ps
`default_nettype none
module tabla_scan #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       f_in,
   input  logic [7:0] expected,
   output logic [2:0] sel,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       match
);
   localparam logic [3:0] c_SETTLE = SETTLE[3:0];

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_sel, w_sel_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_table, w_table_nxt, w_table_smp;
   logic       r_match, w_match_nxt;
   logic       w_cmp;
   logic       w_go;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sel   <= 3'd0;
         r_cnt   <= 4'd0;
         r_table <= 8'h00;
         r_match <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_cnt   <= w_cnt_nxt;
         r_table <= w_table_nxt;
         r_match <= w_match_nxt;
      end
   end

   assign w_go = start & ~abort;

   // Table as it will look after this cycle's sample; feeds the comparator too.
   always_comb begin
      w_table_smp        = r_table;
      w_table_smp[r_sel] = f_in;
   end

`ifdef TABLA_CHECK_EN
   assign w_cmp = (w_table_smp == expected);
`else
   logic w_unused_expected;
   assign w_unused_expected = ^expected;
   assign w_cmp             = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_cnt_nxt   = r_cnt;
      w_table_nxt = r_table;
      w_match_nxt = r_match;
      case (r_state)
         S_IDLE: begin
            if (w_go) begin
               w_state_nxt = S_DRIVE;
               w_sel_nxt   = 3'd0;
               w_cnt_nxt   = 4'd0;
               w_table_nxt = 8'h00;
               w_match_nxt = 1'b0;
            end
         end
         S_DRIVE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_sel_nxt   = 3'd0;
               w_cnt_nxt   = 4'd0;
               w_table_nxt = 8'h00;
               w_match_nxt = 1'b0;
            end else if (r_cnt != c_SETTLE) begin
               w_cnt_nxt = r_cnt + 4'd1;
            end else begin
               w_table_nxt = w_table_smp;
               w_cnt_nxt   = 4'd0;
               if (r_sel == 3'd7) begin
                  w_state_nxt = S_DONE;
                  w_match_nxt = w_cmp;
               end else begin
                  w_sel_nxt = r_sel + 3'd1;
               end
            end
         end
         S_DONE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_match_nxt = 1'b0;
            end else if (start) begin
               w_state_nxt = S_DRIVE;
               w_sel_nxt   = 3'd0;
               w_cnt_nxt   = 4'd0;
               w_table_nxt = 8'h00;
               w_match_nxt = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign sel       = r_sel;
   assign busy      = (r_state == S_DRIVE);
   assign done      = (r_state == S_DONE);
   assign table_out = r_table;
   assign match     = r_match;

endmodule
`default_nettype wire

// File: tb/tb_tabla_scan.sv
// tb_tabla_scan: three scanners (SETTLE = 2, 0, 15) checked cycle by cycle against
// an arithmetic model of the sweep timing plus table-driven and random vectors.
`timescale 1ns/1ps
`default_nettype none
module tb_tabla_scan;
   localparam int SETL [3] = '{2, 0, 15};
`ifdef TABLA_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [2:0] start_v, abort_v, f_v;
   logic [7:0] exp_v   [3];
   logic [2:0] sel_v   [3];
   logic       busy_v  [3];
   logic       done_v  [3];
   logic [7:0] tab_v   [3];
   logic       match_v [3];

   int n_tests = 0;
   int n_fail  = 0;

   tabla_scan #(.SETTLE(2)) u_s2 (
      .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]), .f_in(f_v[0]),
      .expected(exp_v[0]), .sel(sel_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .table_out(tab_v[0]), .match(match_v[0]));
   tabla_scan #(.SETTLE(0)) u_s0 (
      .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]), .f_in(f_v[1]),
      .expected(exp_v[1]), .sel(sel_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .table_out(tab_v[1]), .match(match_v[1]));
   tabla_scan #(.SETTLE(15)) u_s15 (
      .clk(clk), .reset(reset), .start(start_v[2]), .abort(abort_v[2]), .f_in(f_v[2]),
      .expected(exp_v[2]), .sel(sel_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .table_out(tab_v[2]), .match(match_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      int         k;
      logic [7:0] tbl;
      logic [7:0] ex;
      bit         late;
      bit         noisy;
      logic [7:0] exp_table;
      bit         exp_match;
   } vec_t;

   // Packed view {busy,done,match,sel,table_out} of one instance.
   function automatic logic [15:0] snap(input int k);
      return {2'b00, busy_v[k], done_v[k], match_v[k], sel_v[k], tab_v[k]};
   endfunction

   function automatic logic [15:0] mk(input bit b, input bit d, input bit m,
                                      input logic [2:0] s, input logic [7:0] t);
      return {2'b00, b, d, m, s, t};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ex);
      n_tests++;
      if (act !== ex) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, ex);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full sweep on instance k; row r is sampled at edge T0 + (r+1)*(S+1).
   task automatic run_sweep(input int k, input logic [7:0] tbl, input logic [7:0] ex,
                            input bit late, input bit noisy,
                            input logic [7:0] etab, input bit em);
      int s, n, row, ph, nsmp;
      logic [7:0] mask;
      s = SETL[k];
      n = 8 * (s + 1);
      exp_v[k]   = ex;
      start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      for (int t = 0; t < n; t++) begin
         row  = t / (s + 1);
         ph   = t % (s + 1);
         nsmp = row;
         mask = 8'((32'd1 << nsmp) - 1);
         chk($sformatf("sweep k%0d t%0d", k, t), snap(k),
             mk(1'b1, 1'b0, 1'b0, 3'(row), tbl & mask));
         if (late && ph != s) f_v[k] = ~tbl[sel_v[k]];
         else                 f_v[k] = tbl[sel_v[k]];
         if (noisy) start_v[k] = 1'($urandom_range(0, 1));
         tick();
      end
      start_v[k] = 1'b0;
      chk($sformatf("done k%0d", k), snap(k), mk(1'b0, 1'b1, em, 3'd7, etab));
   endtask

   vec_t vecs[$];
   logic [7:0] rt, re;
   int rk;

   initial begin
      reset   = 1'b1;
      start_v = '0;
      abort_v = '0;
      f_v     = '0;
      for (int i = 0; i < 3; i++) exp_v[i] = 8'h00;

      vecs.push_back('{0, 8'h96, 8'h96, 1'b0, 1'b0, 8'h96, CHK});
      vecs.push_back('{1, 8'h71, 8'h96, 1'b0, 1'b0, 8'h71, 1'b0});
      vecs.push_back('{2, 8'hA5, 8'hA5, 1'b1, 1'b0, 8'hA5, CHK});
      vecs.push_back('{0, 8'h3C, 8'h3C, 1'b0, 1'b1, 8'h3C, CHK});
      vecs.push_back('{0, 8'h3C, 8'h3C, 1'b0, 1'b1, 8'h3C, CHK});
      vecs.push_back('{1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, CHK});
      vecs.push_back('{1, 8'hFF, 8'hFE, 1'b0, 1'b0, 8'hFF, 1'b0});
      vecs.push_back('{2, 8'h5A, 8'h5B, 1'b1, 1'b0, 8'h5A, 1'b0});

      // Reset state
      tick();
      tick();
      for (int k = 0; k < 3; k++)
         chk($sformatf("reset k%0d", k), snap(k), 16'h0000);
      reset = 1'b0;
      tick();

      // Asynchronous reset 10 cycles into a sweep
      f_v[0]     = 1'b1;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (10) tick();
      chk("pre-reset busy", snap(0), mk(1'b1, 1'b0, 1'b0, 3'd3, 8'h07));
      reset = 1'b1;
      #1;
      chk("async reset", snap(0), 16'h0000);
      tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("idle after reset", snap(0), 16'h0000);

      // Abort at row 4 with start in the same cycle
      f_v[0]     = 1'b1;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      repeat (12) tick();
      chk("row4 reached", snap(0), mk(1'b1, 1'b0, 1'b0, 3'd4, 8'h0F));
      abort_v[0] = 1'b1;
      start_v[0] = 1'b1;
      tick();
      abort_v[0] = 1'b0;
      start_v[0] = 1'b0;
      chk("abort+start", snap(0), 16'h0000);
      tick();
      chk("start ignored", snap(0), 16'h0000);

      // Table-driven vectors
      foreach (vecs[i])
         run_sweep(vecs[i].k, vecs[i].tbl, vecs[i].ex, vecs[i].late, vecs[i].noisy,
                   vecs[i].exp_table, vecs[i].exp_match);

      // Abort from DONE keeps the captured table
      abort_v[1] = 1'b1;
      tick();
      abort_v[1] = 1'b0;
      chk("done abort busy/done/match", {14'b0, busy_v[1], done_v[1]}, 16'h0000);
      chk("done abort match", {15'b0, match_v[1]}, 16'h0000);
      chk("done abort table kept", {8'b0, tab_v[1]}, 16'h00FF);

      // Randomized sweeps against the model
      for (int i = 0; i < 10; i++) begin
         rk = int'($urandom_range(0, 1));
         rt = 8'($urandom);
         re = ($urandom_range(0, 1) == 1) ? rt : 8'($urandom);
         run_sweep(rk, rt, re, 1'b0, 1'($urandom_range(0, 1)), rt, CHK && (rt == re));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
